// File: rtl/mux_8x1_4bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mux_8x1_4bit : registered 8:1 selector with enable; optional MUX8_PARITY_EN
// Revision: 1.0
// ============================================================================
module mux_8x1_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic             sel0,
    input  logic             sel1,
    input  logic             sel2,
    input  logic             enable,
`ifdef MUX8_PARITY_EN
    output logic             out_parity,
`endif
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [2:0]       w_sel;
    logic [WIDTH-1:0] w_pick;
    logic [WIDTH-1:0] out_d;
    logic             valid_d;
    logic [WIDTH-1:0] out_q;
    logic             valid_q;

    assign w_sel = {sel2, sel1, sel0};

    always_comb begin
        w_pick = a;
        case (w_sel)
            3'd0: w_pick = a;
            3'd1: w_pick = b;
            3'd2: w_pick = c;
            3'd3: w_pick = d;
            3'd4: w_pick = e;
            3'd5: w_pick = f;
            3'd6: w_pick = g;
            3'd7: w_pick = h;
            default: w_pick = a;
        endcase
    end

    // A disabled cycle loads zero rather than holding the previous word.
    assign out_d   = enable ? w_pick : '0;
    assign valid_d = enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

`ifdef MUX8_PARITY_EN
    logic parity_d;
    logic parity_q;

    assign parity_d = ^out_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_8x1_4bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mux_8x1_4bit : self-checking bench with a reference model for mux_8x1_4bit
// Revision: 1.0
// ============================================================================
module tb_mux_8x1_4bit;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din [8];
    logic [2:0]       sel;
    logic             enable;
    logic [WIDTH-1:0] out;
    logic             out_valid;
`ifdef MUX8_PARITY_EN
    logic             out_parity;
`endif

    int total = 0;
    int bad   = 0;

    mux_8x1_4bit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (din[0]),
        .b         (din[1]),
        .c         (din[2]),
        .d         (din[3]),
        .e         (din[4]),
        .f         (din[5]),
        .g         (din[6]),
        .h         (din[7]),
        .sel0      (sel[0]),
        .sel1      (sel[1]),
        .sel2      (sel[2]),
        .enable    (enable),
`ifdef MUX8_PARITY_EN
        .out_parity(out_parity),
`endif
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what the output register must hold after the last edge.
    logic [WIDTH-1:0] m_out;
    logic             m_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out   <= '0;
            m_valid <= 1'b0;
        end else begin
            m_out   <= enable ? din[sel] : '0;
            m_valid <= enable;
        end
    end

    function automatic bit parity_of(input logic [WIDTH-1:0] v);
        bit p = 1'b0;
        for (int i = 0; i < WIDTH; i++) p = p ^ v[i];
        return p;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    bit model_chk = 1'b0;

    always @(negedge clk) begin
        if (model_chk) begin
            check("model_out",   int'(out),       int'(m_out));
            check("model_valid", int'(out_valid), int'(m_valid));
`ifdef MUX8_PARITY_EN
            check("model_parity", int'(out_parity), int'(parity_of(m_out)));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 8; i++) din[i] = 4'(i);
    endtask

    initial begin
        rst_n  = 1'b1;
        enable = 1'b1;
        sel    = 3'd0;
        load_ramp();
        #1 rst_n = 1'b0;
        #1;
        check("reset_out",   int'(out),       0);
        check("reset_valid", int'(out_valid), 0);
        model_chk = 1'b1;

        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("release_out",   int'(out),       0);
        check("release_valid", int'(out_valid), 1);

        // Select sweep, each code held two cycles
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick();
            check("sweep_out", int'(out), s);
            check("sweep_valid", int'(out_valid), 1);
            tick();
            check("sweep_hold", int'(out), s);
        end

        // Enable gating
        sel = 3'd5;
        enable = 1'b1; tick();
        check("en1_out", int'(out), 5);
        check("en1_valid", int'(out_valid), 1);
        enable = 1'b0; tick();
        check("en0_out", int'(out), 0);
        check("en0_valid", int'(out_valid), 0);
        enable = 1'b1; tick();
        check("en1b_out", int'(out), 5);
        check("en1b_valid", int'(out_valid), 1);

        // Mid-cycle select change is not seen until the next edge
        sel = 3'd3; tick();
        check("samp_before", int'(out), 3);
        #2 sel = 3'd6;
        #1 check("samp_between", int'(out), 3);
        tick();
        check("samp_after", int'(out), 6);

        // Asynchronous reset between edges
        sel = 3'd7; tick();
        check("pre_rst_out", int'(out), 7);
        #2 rst_n = 1'b0;
        #1;
        check("async_out",   int'(out),       0);
        check("async_valid", int'(out_valid), 0);
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_out",   int'(out),       7);
        check("post_rst_valid", int'(out_valid), 1);

        // Distinct data patterns; only the chosen word may appear
        din[0] = 4'hF; din[1] = 4'hA; din[2] = 4'h5; din[3] = 4'hC;
        din[4] = 4'h3; din[5] = 4'h9; din[6] = 4'h6; din[7] = 4'hE;
        sel = 3'd0; tick();
        check("pat_a", int'(out), 15);
        sel = 3'd4; tick();
        check("pat_e", int'(out), 3);
        sel = 3'd7; tick();
        check("pat_h", int'(out), 14);
        for (int i = 0; i < 8; i++) begin
            sel = 3'(7 - i);
            enable = (i % 3) != 2;
            tick();
        end
        enable = 1'b1;
        for (int i = 0; i < 8; i++) din[i] = 4'hF ^ 4'(i);
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            tick();
        end

`ifdef MUX8_PARITY_EN
        load_ramp();
        sel = 3'd3; tick();
        check("par_d3", int'(out_parity), 0);
        sel = 3'd7; tick();
        check("par_h7", int'(out_parity), 1);
        enable = 1'b0; tick();
        check("par_dis", int'(out_parity), 0);
        enable = 1'b1;
`endif

        tick();
        model_chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        bad++;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mux_8x1_4bit.md
Name: mux_8x1_4bit

Overview:
Registered 8-to-1 multiplexer for 4-bit data words with an active-high enable. Three discrete select bits choose one of eight input buses. The chosen word is captured into an output register on each rising clock edge. Used as a generic registered data selector in datapaths that need a glitch-free, clock-aligned selected value.

Parameters:
- WIDTH, 4, bit width of every data input and of out (spec and tests use default 4).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  data input, selected when {sel2,sel1,sel0}=0.
- b  input  WIDTH  data input, select 1.
- c  input  WIDTH  data input, select 2.
- d  input  WIDTH  data input, select 3.
- e  input  WIDTH  data input, select 4.
- f  input  WIDTH  data input, select 5.
- g  input  WIDTH  data input, select 6.
- h  input  WIDTH  data input, select 7.
- sel0  input  1  select bit, LSB.
- sel1  input  1  select bit, middle.
- sel2  input  1  select bit, MSB.
- enable  input  1  active-high output enable.
- out  output  WIDTH  registered selected word.
- out_valid  output  1  high while out holds an enabled selection.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Instances connect ports by name; declaration order is as listed above.
- Select index = {sel2,sel1,sel0}, values 0..7, mapping to a..h in order.
- Reset: rst_n low forces out=0 and out_valid=0 immediately, independent of clk. These values hold while rst_n is low.
- Reset release: the first rising edge with rst_n high performs a normal update.
- Each rising clk edge with rst_n high and enable=1:
  - out <= selected input;
  - out_valid <= 1.
- Each rising clk edge with rst_n high and enable=0:
  - out <= 0;
  - out_valid <= 0.
- Latency: exactly 1 cycle from inputs, select and enable to out.
- No combinational path from any input to out.
- Select or data changes between edges have no effect until the next edge. Only values present at the edge are sampled.
- All 8 select codes are legal; there is no default or illegal case.
- X/Z on select is not defined behaviour; the bench never drives it.
- Width: out is a straight copy of the selected input. No arithmetic, no truncation.
- Reset asserted mid-operation: out and out_valid clear asynchronously, within the same timestep.
- Simultaneous reset deassertion and clock edge: reset wins for that edge.

Optional Feature:
- Macro: MUX8_PARITY_EN.
- Defined:
  - adds output out_parity (1 bit), registered alongside out;
  - out_parity equals the XOR-reduction (even-parity bit) of the word loaded into out;
  - out_parity is 0 on reset and when enable=0.
- Not defined: port out_parity is absent. All other behaviour is unchanged.

Test Plan:
- Reset: a..h=0..7, enable=1, rst_n=0 -> out=0, out_valid=0 with no clk edge needed. Release rst_n, then one edge with sel=0 -> out=0, out_valid=1.
- Select sweep: a=0,b=1,...,h=7, enable=1. Step {sel2,sel1,sel0} 0..7, holding each code 2 cycles -> out equals the select code one cycle after each change, out_valid=1 throughout.
- Enable gating: sel=5 (f=5), enable toggles 1,0,1 on successive cycles -> out 5,0,5 and out_valid 1,0,1, each one cycle later.
- Sampling: sel changes 3->6 between clock edges -> out stays 3 until the next rising edge, then becomes 6. No glitch between edges.
- Async reset mid-run: out=7 (sel=7), pull rst_n low between edges -> out=0 and out_valid=0 at once. Release rst_n -> next edge gives 7 again.
- Parity (MUX8_PARITY_EN defined): sel=3 (d=3) gives out_parity=0; sel=7 (h=7) gives out_parity=1; enable=0 gives out_parity=0.
